blink_multi: RTL and testbench

Parametrised multi-channel successor to the single-rate 1 Hz blinker. Divides the 100 MHz board clock into CHANNELS independent outputs. Each channel has a runtime-programmable half-period and a mode: toggle, pulse, one-shot or hold. Configuration arrives through a valid/ready port and takes effect only on a channel's terminal count, so outputs never glitch. Sits between the board clock and LED or slow-strobe consumers.

---
 rtl/blink_multi.sv | 198 +++++++++++++++++++
 tb/tb_blink_multi.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/blink_multi.sv
// blink_multi: multi-channel programmable clock divider for LEDs and slow strobes.
// Each channel has a runtime half-period and one of four modes (toggle, pulse,
// one-shot, hold-low). New settings are staged in a shadow register and only
// take effect on the channel's terminal count or while it is disabled, so the
// outputs never glitch.
//
// Ports:
//   i_clk_100MHz  system clock (only clock)
//   i_clr         asynchronous active-high reset
//   i_en          per-channel run enable
//   i_cfg_valid   config request
//   o_cfg_ready   config accept (combinational): no config pending on i_cfg_ch;
//                 always 1 for an out-of-range channel
//   i_cfg_ch      target channel
//   i_cfg_half    new half value (terminal count)
//   i_cfg_mode    0 toggle, 1 pulse, 2 one-shot, 3 hold-low
//   o_clk         divided outputs
//   o_tick        one-cycle strobe after every terminal count
//   o_done        sticky one-shot finished flag
module blink_multi #(
   parameter int unsigned CHANNELS     = 4,
   parameter int unsigned CNT_W        = 32,
   parameter int unsigned DEFAULT_HALF = 49_999_999,
   parameter int unsigned CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                i_clk_100MHz,
   input  logic                i_clr,
   input  logic [CHANNELS-1:0] i_en,
   input  logic                i_cfg_valid,
   output logic                o_cfg_ready,
   input  logic [CH_W-1:0]     i_cfg_ch,
   input  logic [CNT_W-1:0]    i_cfg_half,
   input  logic [1:0]          i_cfg_mode,
   output logic [CHANNELS-1:0] o_clk,
   output logic [CHANNELS-1:0] o_tick,
   output logic [CHANNELS-1:0] o_done
);

   typedef enum logic [1:0] {
      MODE_TOGGLE  = 2'd0,
      MODE_PULSE   = 2'd1,
      MODE_ONESHOT = 2'd2,
      MODE_HOLD    = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      OS_ARM  = 2'd0,
      OS_HIGH = 2'd1,
      OS_DONE = 2'd2
   } os_e;

   logic [CNT_W-1:0]    cnt_q   [CHANNELS];
   logic [CNT_W-1:0]    cnt_d   [CHANNELS];
   logic [CNT_W-1:0]    half_q  [CHANNELS];
   logic [CNT_W-1:0]    half_d  [CHANNELS];
   logic [CNT_W-1:0]    shalf_q [CHANNELS];
   logic [CNT_W-1:0]    shalf_d [CHANNELS];
   mode_e               mode_q  [CHANNELS];
   mode_e               mode_d  [CHANNELS];
   mode_e               smode_q [CHANNELS];
   mode_e               smode_d [CHANNELS];
   os_e                 os_q    [CHANNELS];
   os_e                 os_d    [CHANNELS];

   logic [CHANNELS-1:0] pend_q, pend_d;
   logic [CHANNELS-1:0] clk_q, clk_d;
   logic [CHANNELS-1:0] tick_q, tick_d;
   logic [CHANNELS-1:0] done_q, done_d;
   logic [CHANNELS-1:0] en_q;

   logic [CHANNELS-1:0] tc_c, apply_c, halt_c;
   logic                cfg_in_range_c;
   logic                cfg_acc_c;

   // Config handshake: an out-of-range channel is always accepted and dropped
   always_comb begin
      cfg_in_range_c = (32'(i_cfg_ch) < CHANNELS);
      o_cfg_ready    = 1'b1;
      if (cfg_in_range_c) begin
         o_cfg_ready = ~pend_q[i_cfg_ch];
      end
      cfg_acc_c = i_cfg_valid & o_cfg_ready & cfg_in_range_c;
   end

   // Per-channel next-state: counter, output shaping, one-shot sequencing, config
   always_comb begin
      tc_c    = '0;
      apply_c = '0;
      halt_c  = '0;
      cnt_d   = cnt_q;
      half_d  = half_q;
      shalf_d = shalf_q;
      mode_d  = mode_q;
      smode_d = smode_q;
      os_d    = os_q;
      pend_d  = pend_q;
      clk_d   = clk_q;
      tick_d  = '0;
      done_d  = done_q;

      for (int i = 0; i < CHANNELS; i++) begin
         halt_c[i]  = (mode_q[i] == MODE_ONESHOT) && (os_q[i] == OS_DONE);
         tc_c[i]    = i_en[i] && (cnt_q[i] == half_q[i]) && !halt_c[i];
         apply_c[i] = pend_q[i] && (tc_c[i] || !i_en[i]);
         tick_d[i]  = tc_c[i];

         // Apply always coincides with TC or disable, both of which clear cnt
         if (!i_en[i] || tc_c[i]) begin
            cnt_d[i] = '0;
         end else if (!halt_c[i]) begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end

         if (!i_en[i]) begin
            clk_d[i] = 1'b0;
         end else begin
            case (mode_q[i])
               MODE_TOGGLE:  if (tc_c[i]) clk_d[i] = ~clk_q[i];
               MODE_PULSE:   clk_d[i] = tc_c[i];
               MODE_ONESHOT: if (tc_c[i]) clk_d[i] = (os_q[i] == OS_ARM);
               default:      clk_d[i] = 1'b0;
            endcase
         end

         // One-shot: ARM -> HIGH -> DONE; a disable period re-arms while done stays set
         if (tc_c[i] && (mode_q[i] == MODE_ONESHOT)) begin
            if (os_q[i] == OS_ARM) begin
               os_d[i] = OS_HIGH;
            end else if (os_q[i] == OS_HIGH) begin
               os_d[i]   = OS_DONE;
               done_d[i] = 1'b1;
            end
         end else if (!i_en[i] && (os_q[i] == OS_DONE)) begin
            os_d[i] = OS_ARM;
         end

         // Done is held through a disable and released when the enable returns
         if (i_en[i] && !en_q[i]) begin
            done_d[i] = 1'b0;
         end

         if (apply_c[i]) begin
            half_d[i] = shalf_q[i];
            mode_d[i] = smode_q[i];
            pend_d[i] = 1'b0;
            os_d[i]   = OS_ARM;
            done_d[i] = 1'b0;
            // Only a toggle->toggle change keeps the phase continuous
            if (!((mode_q[i] == MODE_TOGGLE) && (smode_q[i] == MODE_TOGGLE))) begin
               clk_d[i] = 1'b0;
            end
         end

         // Accept and apply are exclusive: ready requires pending clear
         if (cfg_acc_c && (CH_W'(i) == i_cfg_ch)) begin
            shalf_d[i] = i_cfg_half;
            smode_d[i] = mode_e'(i_cfg_mode);
            pend_d[i]  = 1'b1;
         end
      end
   end

   // State registers
   always_ff @(posedge i_clk_100MHz or posedge i_clr) begin
      if (i_clr) begin
         for (int i = 0; i < CHANNELS; i++) begin
            cnt_q[i]   <= '0;
            half_q[i]  <= CNT_W'(DEFAULT_HALF);
            shalf_q[i] <= CNT_W'(DEFAULT_HALF);
            mode_q[i]  <= MODE_TOGGLE;
            smode_q[i] <= MODE_TOGGLE;
            os_q[i]    <= OS_ARM;
         end
         pend_q <= '0;
         clk_q  <= '0;
         tick_q <= '0;
         done_q <= '0;
         en_q   <= '0;
      end else begin
         cnt_q   <= cnt_d;
         half_q  <= half_d;
         shalf_q <= shalf_d;
         mode_q  <= mode_d;
         smode_q <= smode_d;
         os_q    <= os_d;
         pend_q  <= pend_d;
         clk_q   <= clk_d;
         tick_q  <= tick_d;
         done_q  <= done_d;
         en_q    <= i_en;
      end
   end

   assign o_clk  = clk_q;
   assign o_tick = tick_q;
   assign o_done = done_q;

endmodule

// File: tb/tb_blink_multi.sv
// tb_blink_multi: vector table with scoreboard for blink_multi (4 channels,
// DEFAULT_HALF=3), plus hand-written sequences for async reset and an
// out-of-range config channel on a 3-channel instance.
module tb_blink_multi;

   logic        clk = 1'b0;
   logic        clr;
   logic [3:0]  en;
   logic        valid;
   logic        ready;
   logic [1:0]  ch;
   logic [31:0] half;
   logic [1:0]  mode;
   logic [3:0]  oclk, otick, odone;

   logic [2:0]  en3;
   logic        valid3;
   logic        ready3;
   logic [1:0]  ch3;
   logic [31:0] half3;
   logic [1:0]  mode3;
   logic [2:0]  oclk3, otick3, odone3;

   always #5 clk = ~clk;

   blink_multi #(.CHANNELS(4), .CNT_W(32), .DEFAULT_HALF(3)) u_dut (
      .i_clk_100MHz (clk),
      .i_clr        (clr),
      .i_en         (en),
      .i_cfg_valid  (valid),
      .o_cfg_ready  (ready),
      .i_cfg_ch     (ch),
      .i_cfg_half   (half),
      .i_cfg_mode   (mode),
      .o_clk        (oclk),
      .o_tick       (otick),
      .o_done       (odone)
   );

   blink_multi #(.CHANNELS(3), .CNT_W(32), .DEFAULT_HALF(3)) u_dut3 (
      .i_clk_100MHz (clk),
      .i_clr        (clr),
      .i_en         (en3),
      .i_cfg_valid  (valid3),
      .o_cfg_ready  (ready3),
      .i_cfg_ch     (ch3),
      .i_cfg_half   (half3),
      .i_cfg_mode   (mode3),
      .o_clk        (oclk3),
      .o_tick       (otick3),
      .o_done       (odone3)
   );

   typedef struct {
      logic [3:0]  en;
      logic        v;
      logic [1:0]  ch;
      logic [31:0] half;
      logic [1:0]  mode;
      logic [3:0]  eclk;
      logic [3:0]  etick;
      logic [3:0]  edone;
      logic        erdy;
   } vec_t;

   vec_t        vecs[$];
   logic [15:0] sb_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;

   task automatic add(input logic [3:0] e, input logic v, input logic [1:0] c,
                      input logic [31:0] h, input logic [1:0] m,
                      input logic [3:0] xc, input logic [3:0] xt,
                      input logic [3:0] xd, input logic xr);
      vec_t x;
      x.en = e; x.v = v; x.ch = c; x.half = h; x.mode = m;
      x.eclk = xc; x.etick = xt; x.edone = xd; x.erdy = xr;
      vecs.push_back(x);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Packed observation: hex digits are clk, tick, done, ready
   function automatic logic [15:0] obs();
      return {oclk, otick, odone, 3'b000, ready};
   endfunction

   task automatic run(input int lo, input int hi);
      logic [15:0] exp;
      for (int k = lo; k < hi; k++) begin
         @(negedge clk);
         en    = vecs[k].en;
         valid = vecs[k].v;
         ch    = vecs[k].ch;
         half  = vecs[k].half;
         mode  = vecs[k].mode;
         sb_q.push_back({vecs[k].eclk, vecs[k].etick, vecs[k].edone, 3'b000, vecs[k].erdy});
         @(posedge clk);
         #1;
         exp = sb_q.pop_front();
         check($sformatf("vec%0d clk/tick/done/rdy", k), 32'(obs()), 32'(exp));
      end
   endtask

   task automatic default_toggle_ch0();
      add(4'b0001, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1);
      add(4'b0001, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1);
      add(4'b0001, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1);
      add(4'b0001, 0, 0, 0, 0, 4'b0001, 4'b0001, 4'b0000, 1);
      add(4'b0001, 0, 0, 0, 0, 4'b0001, 4'b0000, 4'b0000, 1);
      add(4'b0001, 0, 0, 0, 0, 4'b0001, 4'b0000, 4'b0000, 1);
      add(4'b0001, 0, 0, 0, 0, 4'b0001, 4'b0000, 4'b0000, 1);
      add(4'b0001, 0, 0, 0, 0, 4'b0000, 4'b0001, 4'b0000, 1);
   endtask

   initial begin
      // Default toggle on ch0, H=3
      default_toggle_ch0();
      // Reconfigure running ch0 to H=1 mid-count; old period completes first
      add(4'b0001, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1);
      add(4'b0001, 1, 0, 1, 0, 4'b0000, 4'b0000, 4'b0000, 0);
      add(4'b0001, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0);
      add(4'b0001, 0, 0, 0, 0, 4'b0001, 4'b0001, 4'b0000, 1);
      add(4'b0001, 0, 0, 0, 0, 4'b0001, 4'b0000, 4'b0000, 1);
      add(4'b0001, 0, 0, 0, 0, 4'b0000, 4'b0001, 4'b0000, 1);
      add(4'b0001, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1);
      add(4'b0001, 0, 0, 0, 0, 4'b0001, 4'b0001, 4'b0000, 1);
      // Disabled ch1 config (pulse H=4) applies in one cycle
      add(4'b0000, 1, 1, 4, 1, 4'b0000, 4'b0000, 4'b0000, 0);
      add(4'b0000, 0, 1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1);
      // Pulse: one-cycle high every 5 cycles
      for (int i = 0; i < 2; i++) begin
         for (int j = 0; j < 4; j++) add(4'b0010, 0, 1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1);
         add(4'b0010, 0, 1, 0, 0, 4'b0010, 4'b0010, 4'b0000, 1);
      end
      // Switch ch1 to hold: apply TC forces clk low, ticks continue
      add(4'b0010, 1, 1, 4, 3, 4'b0000, 4'b0000, 4'b0000, 0);
      for (int j = 0; j < 3; j++) add(4'b0010, 0, 1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0);
      add(4'b0010, 0, 1, 0, 0, 4'b0000, 4'b0010, 4'b0000, 1);
      for (int j = 0; j < 4; j++) add(4'b0010, 0, 1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1);
      add(4'b0010, 0, 1, 0, 0, 4'b0000, 4'b0010, 4'b0000, 1);
      // One-shot on ch2, H=2
      add(4'b0000, 1, 2, 2, 2, 4'b0000, 4'b0000, 4'b0000, 0);
      add(4'b0000, 0, 2, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1);
      add(4'b0100, 0, 2, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1);
      add(4'b0100, 0, 2, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1);
      add(4'b0100, 0, 2, 0, 0, 4'b0100, 4'b0100, 4'b0000, 1);
      add(4'b0100, 0, 2, 0, 0, 4'b0100, 4'b0000, 4'b0000, 1);
      add(4'b0100, 0, 2, 0, 0, 4'b0100, 4'b0000, 4'b0000, 1);
      add(4'b0100, 0, 2, 0, 0, 4'b0000, 4'b0100, 4'b0100, 1);
      for (int j = 0; j < 4; j++) add(4'b0100, 0, 2, 0, 0, 4'b0000, 4'b0000, 4'b0100, 1);
      // Re-arm via enable low then high
      add(4'b0000, 0, 2, 0, 0, 4'b0000, 4'b0000, 4'b0100, 1);
      add(4'b0100, 0, 2, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1);
      add(4'b0100, 0, 2, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1);
      add(4'b0100, 0, 2, 0, 0, 4'b0100, 4'b0100, 4'b0000, 1);
      add(4'b0000, 0, 2, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1);
      // H=0 toggle on ch3: period 2
      add(4'b0000, 1, 3, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0);
      add(4'b0000, 0, 3, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1);
      add(4'b1000, 0, 3, 0, 0, 4'b1000, 4'b1000, 4'b0000, 1);
      add(4'b1000, 0, 3, 0, 0, 4'b0000, 4'b1000, 4'b0000, 1);
      add(4'b1000, 0, 3, 0, 0, 4'b1000, 4'b1000, 4'b0000, 1);
      add(4'b1000, 0, 3, 0, 0, 4'b0000, 4'b1000, 4'b0000, 1);
      add(4'b0000, 0, 3, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1);
      // Same-edge accept and TC on ch0 (H=1): apply deferred to next TC
      add(4'b0001, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1);
      add(4'b0001, 0, 0, 0, 0, 4'b0001, 4'b0001, 4'b0000, 1);
      add(4'b0001, 0, 0, 0, 0, 4'b0001, 4'b0000, 4'b0000, 1);
      add(4'b0001, 1, 0, 3, 0, 4'b0000, 4'b0001, 4'b0000, 0);
      add(4'b0001, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0);
      add(4'b0001, 0, 0, 0, 0, 4'b0001, 4'b0001, 4'b0000, 1);
      for (int j = 0; j < 3; j++) add(4'b0001, 0, 0, 0, 0, 4'b0001, 4'b0000, 4'b0000, 1);
      add(4'b0001, 0, 0, 0, 0, 4'b0000, 4'b0001, 4'b0000, 1);
      // Run up to clk high and leave a pending config before reset
      for (int j = 0; j < 3; j++) add(4'b0001, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1);
      add(4'b0001, 0, 0, 0, 0, 4'b0001, 4'b0001, 4'b0000, 1);
      add(4'b0001, 1, 0, 1, 1, 4'b0001, 4'b0000, 4'b0000, 0);
      // After reset: default toggle again, no pending config
      default_toggle_ch0();

      clr = 1'b1; en = '0; valid = 1'b0; ch = '0; half = '0; mode = '0;
      en3 = '0; valid3 = 1'b0; ch3 = '0; half3 = '0; mode3 = '0;
      #2;
      check("reset_state", 32'(obs()), 32'h0001);
      check("reset_state3", 32'({oclk3, otick3, odone3, ready3}), 32'h001);
      @(negedge clk);
      clr = 1'b0;

      run(0, 77);

      // Async reset mid-count with ch0 high and a config pending
      @(negedge clk);
      clr = 1'b1; en = '0; valid = 1'b0; ch = '0;
      #1;
      check("mid_reset", 32'(obs()), 32'h0001);
      @(negedge clk);
      clr = 1'b0;

      run(77, 85);

      // Out-of-range channel on a 3-channel instance: accepted, discarded
      @(negedge clk);
      valid3 = 1'b1; ch3 = 2'd3; half3 = 32'd0; mode3 = 2'd1;
      #1;
      check("oor_ready_pre", 32'(ready3), 32'd1);
      @(posedge clk);
      #1;
      check("oor_ready_post", 32'(ready3), 32'd1);
      @(negedge clk);
      valid3 = 1'b0;
      for (int c = 0; c < 3; c++) begin
         ch3 = 2'(c);
         #1;
         check($sformatf("oor_no_pending_ch%0d", c), 32'(ready3), 32'd1);
      end
      en3 = 3'b001;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("oor_default_run%0d", k), 32'({oclk3, otick3}),
               (k == 3) ? 32'h09 : 32'h00);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
